// File: rtl/pll_reset_seq.sv
// Reset/lock sequencer between the system PLL wrapper and the core: pulses the
// PLL reset, waits for a stable lock, then releases a registered core reset.
module pll_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_reset,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] retry_count,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int MAX_A    = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_TERM = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int PH_W     = $clog2(MAX_TERM + 1);

  localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(LOCK_TIMEOUT - 1);
  localparam logic [PH_W-1:0] STABLE_LAST = PH_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [PH_W-1:0]        phase;
  logic [1:0]             state_nxt;
  logic                   phase_clr;
  logic                   retry_inc;
  logic                   drop_in_run;

  // pll_locked comes from the PLL's own clock domain; every decision below
  // looks only at the last synchronizer stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt   = state;
    phase_clr   = 1'b0;
    retry_inc   = 1'b0;
    drop_in_run = 1'b0;
    if (soft_reset) begin
      state_nxt = ST_PLL_RST;
      phase_clr = 1'b1;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (phase == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            phase_clr = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = ST_STABLE;
            phase_clr = 1'b1;
          end else if (phase == TIMEOUT_LAST) begin
            state_nxt = ST_PLL_RST;
            phase_clr = 1'b1;
            retry_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_nxt = ST_WAIT_LOCK;
            phase_clr = 1'b1;
          end else if (phase == STABLE_LAST) begin
            state_nxt = ST_RUN;
            phase_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_nxt   = ST_PLL_RST;
            phase_clr   = 1'b1;
            drop_in_run = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_PLL_RST;
          phase_clr = 1'b1;
        end
      endcase
    end
  end

  // The phase counter saturates so a long stay in RUN never wraps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase_clr) begin
      phase <= '0;
    end else if (phase != '1) begin
      phase <= phase + PH_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // that enters the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLL_RST;
      pll_rst     <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state     <= state_nxt;
      pll_rst   <= (state_nxt == ST_PLL_RST);
      sys_reset <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      lock_lost <= drop_in_run;
      if (retry_inc && (retry_count != '1)) begin
        retry_count <= retry_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset/lock sequencer sitting directly downstream of the system PLL wrapper.
- Runs on the free-running 50 MHz reference clock and drives the PLL's rst input.
- Consumes the PLL's asynchronous locked output and produces a clean, registered system reset for the core, released only after lock has been stable for a programmable time.
- On lock timeout, lock loss or soft reset, it re-resets the PLL and retries, keeping a saturating retry count.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2).
- RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (min 1).
- LOCK_TIMEOUT, 500000, cycles to wait for lock before re-resetting the PLL (10 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_reset (min 1).
- CNT_W, 8, width of retry_count.

Ports:
- clk, in, 1: reference clock, same net as the PLL refclk.
- rst_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL locked output; asynchronous to clk.
- soft_reset, in, 1: synchronous level request to restart the full sequence.
- pll_rst, out, 1: active-high reset to the PLL rst input.
- sys_reset, out, 1: active-high reset to the core.
- ready, out, 1: high while in RUN.
- lock_lost, out, 1: one-cycle pulse when lock drops while in RUN.
- retry_count, out, CNT_W: number of lock timeouts; saturates at all-ones.
- state, out, 2: 0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - Ports are named clk and rst_n.
- Reset values (rst_n low):
  - state=PLL_RST, pll_rst=1, sys_reset=1, ready=0, lock_lost=0, retry_count=0.
  - Synchronizer flops are cleared to 0.
  - Phase counter is cleared to 0.
- Synchronization and registering:
  - pll_locked passes through SYNC_STAGES flops to give locked_s.
  - All decisions use locked_s, so latency is SYNC_STAGES cycles.
  - All outputs are registered and change only on clk edges, after rst_n deassertion.
- One shared phase counter:
  - Cleared to 0 on every state entry.
  - Increments once per cycle spent in a state.
- PLL_RST:
  - pll_rst=1, sys_reset=1.
  - After exactly RST_CYCLES cycles in this state (counter==RST_CYCLES-1), go to WAIT_LOCK.
  - Ignores locked_s.
- WAIT_LOCK:
  - pll_rst=0, sys_reset=1.
  - If locked_s=1, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1, go to PLL_RST and increment retry_count (saturating: stays at 2^CNT_W-1).
- STABLE:
  - pll_rst=0, sys_reset=1.
  - If locked_s=0, go to WAIT_LOCK with the counter cleared; no retry increment.
  - If locked_s=1 and counter==STABLE_CYCLES-1, go to RUN.
  - STABLE therefore lasts exactly STABLE_CYCLES cycles when lock holds.
- RUN:
  - sys_reset=0, ready=1; both take effect on the edge that enters RUN.
  - If locked_s=0: on the next edge go to PLL_RST, set sys_reset=1 and ready=0, and pulse lock_lost=1 for exactly one cycle.
  - retry_count is not incremented on lock loss.
- soft_reset:
  - Highest priority in every state.
  - Forces PLL_RST on the next edge with the counter cleared and sys_reset=1, ready=0.
  - While held, the block stays in PLL_RST with the counter held at 0.
  - The sequence restarts when soft_reset is released.
  - No lock_lost pulse and no retry increment.
- Simultaneous events: if soft_reset and a lock drop in RUN occur together, soft_reset wins (no lock_lost pulse).
- retry_count clears only on rst_n.
- Glitches on pll_locked shorter than one clk period may be missed; that is acceptable.
- rst_n asserted mid-sequence returns all outputs to reset values immediately (asynchronously).

Test Plan:
- Params SYNC_STAGES=2, RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8 for all tests.
- Nominal bring-up:
  - Release rst_n; pll_rst high for exactly 4 cycles.
  - Raise pll_locked 3 cycles later; state goes 0→1→2→3.
  - sys_reset falls exactly 2+1+8 cycles after the pll_locked rise edge; ready=1.
- Lock timeout:
  - Hold pll_locked=0.
  - pll_rst re-pulses (4 cycles) after every 20 WAIT_LOCK cycles.
  - retry_count reads 1, 2, 3; with CNT_W=2 it saturates at 3.
- Unstable lock:
  - Drop pll_locked for 3 cycles at STABLE count 5.
  - Block returns to WAIT_LOCK and restarts STABLE counting on relock; retry_count unchanged; sys_reset stays 1.
- Lock loss in RUN:
  - Drop pll_locked.
  - Exactly SYNC_STAGES+1 edges later: sys_reset=1, ready=0, lock_lost high for one cycle, state=0, pll_rst=1.
- soft_reset:
  - Assert in RUN for 10 cycles: state held 0, pll_rst high, no lock_lost pulse.
  - After release: 4-cycle pll_rst, then the normal sequence resumes.
- Async reset mid-STABLE:
  - Assert rst_n low between clk edges.
  - Outputs are at reset values before the next edge; retry_count=0.
